mem_stage_ctrl: RTL
===================

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15: the maximum ACCESS cycles to wait for bus_ack before aborting.
REQ-002 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 The block SHALL have ports malu/mb, input, 32 each: ALU result (address) and store data from the EXE/MEM register.
REQ-005 The block SHALL have port mrn, input, 5: destination register number.
REQ-006 The block SHALL have ports mwreg/mm2reg/mwmem, input, 1 each: register-write, load and store controls.
REQ-007 The block SHALL have ports bus_req/bus_we, output, 1 each: memory request and write-enable.
REQ-008 The block SHALL have ports bus_addr/bus_wdata, output, 32 each: memory address and write data.
REQ-009 The block SHALL have ports bus_rdata input 32 and bus_ack input 1: read data and one-cycle completion strobe.
REQ-010 The block SHALL have port stall, output, 1: combinational hold request to the upstream pipeline.
REQ-011 The block SHALL have ports walu/wmo, output, 32 each: the MEM/WB ALU result and loaded data.
REQ-012 The block SHALL have ports wrn output 5, and wwreg/wm2reg output 1 each: the MEM/WB destination and controls.
REQ-013 The block SHALL have ports misalign/bus_err, output, 1 each: single-cycle registered fault pulses.

Function
REQ-014 An "access" SHALL be defined as mm2reg|mwmem; if both are set, the store (mwmem) SHALL take precedence and wm2reg SHALL be 0.
REQ-015 The FSM SHALL have exactly two states, IDLE and ACCESS.
REQ-016 IDLE, no access: at the next edge, walu<=malu, wrn<=mrn, wwreg<=mwreg, wm2reg<=0 and wmo holds; stall=0; one-cycle latency.
REQ-017 IDLE, access with malu[1:0]!=0: no bus transaction; stall=0; next edge: wwreg<=0, wm2reg<=0, misalign<=1 for one cycle.
REQ-018 IDLE, aligned access: stall=1 that cycle.
REQ-019 At the next edge after REQ-018, the block SHALL latch malu/mb/mrn/mwreg/mm2reg/mwmem internally, move to ACCESS, clear the timeout counter, and load a bubble into MEM/WB (wwreg<=0).
REQ-020 ACCESS: bus_req=1; bus_we=latched mwmem; bus_addr=latched malu; bus_wdata=latched mb; all driven from registers and stable until exit.
REQ-021 ACCESS: stall=1 except in the cycle bus_ack=1, where stall=0.
REQ-022 On bus_ack in ACCESS, at that edge: walu<=latched addr, wrn<=latched rn, wwreg<=latched wreg & ~latched wmem, wm2reg<=latched m2reg & ~latched wmem.
REQ-023 On bus_ack in ACCESS, at that edge: wmo<=bus_rdata for a load (wmo holds for a store); bus_req<=0; state<=IDLE.
REQ-024 In ACCESS without ack, the counter SHALL increment each cycle.
REQ-025 When the counter equals TIMEOUT-1 without ack: stall=0 that cycle; next edge: bus_req<=0, MEM/WB bubble, bus_err<=1 for one cycle, state<=IDLE.
REQ-026 bus_ack and the timeout in the same cycle SHALL be treated as completion: no bus_err.
REQ-027 bus_ack while in IDLE SHALL be ignored.
REQ-028 The cycle after returning to IDLE SHALL evaluate the new EXE/MEM contents per REQ-016 to REQ-019; there are no dead cycles.
REQ-029 The counter SHALL be 8 bits wide and SHALL saturate rather than wrap.

Reset
REQ-030 While rst=1, asynchronously: state=IDLE, counter=0, and every registered output (bus_req, bus_we, bus_addr, bus_wdata, walu, wmo, wrn, wwreg, wm2reg, misalign, bus_err) =0.
REQ-031 While rst=1, stall=0.
REQ-032 rst asserted mid-ACCESS SHALL abandon the transaction with no bus_err pulse.
REQ-033 The block SHALL resume on the first clk edge after rst falls.

Verification
REQ-034 The bench SHALL cover ALU pass-through: malu=0x1234, mrn=5, mwreg=1, no access -> next edge walu=0x1234, wrn=5, wwreg=1, stall=0 throughout.
REQ-035 The bench SHALL cover a load with 2-cycle ack delay: malu=0x100, mm2reg=1, mwreg=1, mrn=8, bus_rdata=0xDEADBEEF -> stall high for 3 cycles and low in the ack cycle; bus_req=1/bus_we=0/bus_addr=0x100; after the ack edge wmo=0xDEADBEEF, wm2reg=1, wwreg=1, wrn=8.
REQ-036 The bench SHALL cover a store: malu=0x200, mb=0xA5A5A5A5, mwmem=1, ack on the first ACCESS cycle -> bus_we=1, bus_wdata=0xA5A5A5A5, after-edge wwreg=0, then IDLE.
REQ-037 The bench SHALL cover a misaligned load: malu=0x102, mm2reg=1 -> bus_req stays 0, stall=0, misalign=1 for exactly one cycle, wwreg=0.
REQ-038 The bench SHALL cover a timeout: load with no ack, TIMEOUT=15 -> bus_err pulses once after 15 ACCESS cycles, bus_req=0, state IDLE; a repeat run with ack in cycle 15 -> no bus_err and normal completion.
REQ-039 The bench SHALL cover reset mid-ACCESS: rst pulsed in ACCESS cycle 3 -> bus_req, stall and all outputs go to 0 immediately with no bus_err; a subsequent load completes normally.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage controller: issues one bus transaction per load/store,
// holds the upstream pipeline while it waits, and fills the MEM/WB register.
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] malu,
    input  logic [31:0] mb,
    input  logic [4:0]  mrn,
    input  logic        mwreg,
    input  logic        mm2reg,
    input  logic        mwmem,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        stall,
    output logic [31:0] walu,
    output logic [31:0] wmo,
    output logic [4:0]  wrn,
    output logic        wwreg,
    output logic        wm2reg,
    output logic        misalign,
    output logic        bus_err
);

    localparam int unsigned CW = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [4:0]    l_rn;
    logic          l_wreg;
    logic          l_m2reg;

    logic access_c;
    logic aligned_c;
    logic timeout_c;

    assign access_c  = mm2reg | mwmem;
    assign aligned_c = (malu[1:0] == 2'b00);
    assign timeout_c = (cnt == CW'(TIMEOUT - 1));

    // Hold request: only an aligned access entering, or an access still waiting.
    always_comb begin
        stall = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:    stall = access_c & aligned_c;
                ACCESS:  stall = ~bus_ack & ~timeout_c;
                default: stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            l_rn      <= '0;
            l_wreg    <= 1'b0;
            l_m2reg   <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            walu      <= '0;
            wmo       <= '0;
            wrn       <= '0;
            wwreg     <= 1'b0;
            wm2reg    <= 1'b0;
            misalign  <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            misalign <= 1'b0;
            bus_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!access_c) begin
                        walu   <= malu;
                        wrn    <= mrn;
                        wwreg  <= mwreg;
                        wm2reg <= 1'b0;
                    end else if (!aligned_c) begin
                        wwreg    <= 1'b0;
                        wm2reg   <= 1'b0;
                        misalign <= 1'b1;
                    end else begin
                        // Capture the access; bus_we/addr/wdata double as the latched copies.
                        l_rn      <= mrn;
                        l_wreg    <= mwreg;
                        l_m2reg   <= mm2reg;
                        bus_we    <= mwmem;
                        bus_addr  <= malu;
                        bus_wdata <= mb;
                        bus_req   <= 1'b1;
                        cnt       <= '0;
                        wwreg     <= 1'b0;
                        wm2reg    <= 1'b0;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (bus_ack) begin
                        walu    <= bus_addr;
                        wrn     <= l_rn;
                        wwreg   <= l_wreg & ~bus_we;
                        wm2reg  <= l_m2reg & ~bus_we;
                        if (!bus_we) begin
                            wmo <= bus_rdata;
                        end
                        bus_req <= 1'b0;
                        state   <= IDLE;
                    end else if (timeout_c) begin
                        bus_req <= 1'b0;
                        wwreg   <= 1'b0;
                        wm2reg  <= 1'b0;
                        bus_err <= 1'b1;
                        state   <= IDLE;
                    end else if (cnt != {CW{1'b1}}) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
